// File: rtl/e203_ifu_jalr_rs1_ctrl.sv
// Sequences the JALR rs1 operand fetch for the IFU branch-target path.
// Optional macro E203_IFU_JALR_X1_FAST_EN enables the dedicated x1 fast path.
module e203_ifu_jalr_rs1_ctrl #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int WCNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               f_valid,
  input  logic               dec_jalr,
  input  logic [RFIDX_W-1:0] dec_rs1idx,
  input  logic               oitf_empty,
  input  logic               ir_valid,
  input  logic               ir_rdwen,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic [XLEN-1:0]    x1_data,
  output logic               rf_rd_req,
  output logic [RFIDX_W-1:0] rf_rd_idx,
  input  logic               rf_rd_gnt,
  input  logic [XLEN-1:0]    rf_rd_data,
  output logic               rs1_vld,
  output logic [XLEN-1:0]    rs1_data,
  input  logic               rs1_rdy,
  output logic               ifu_hold,
  output logic [WCNT_W-1:0]  wait_cnt
);

`ifdef E203_IFU_JALR_X1_FAST_EN
  localparam logic FAST_X1 = 1'b1;
`else
  localparam logic FAST_X1 = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [RFIDX_W-1:0] IDX_X1 = RFIDX_W'(1);

  logic [1:0]         state_q, state_d;
  logic [RFIDX_W-1:0] rs1idx_q, rs1idx_d;
  logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              start;
  logic              dep_dec;
  logic              dep_lat;
  logic              imm_hit;
  logic [XLEN-1:0]   imm_data;
  logic [WCNT_W-1:0] wait_inc;

  assign dep_dec  = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == dec_rs1idx));
  assign dep_lat  = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == rs1idx_q));
  assign start    = f_valid & dec_jalr & (state_q == ST_IDLE) & ~flush;

  // x0 always resolves in the start cycle; x1 only with the fast path and no hazard.
  assign imm_hit  = start & ((dec_rs1idx == '0)
                    | (FAST_X1 & (dec_rs1idx == IDX_X1) & ~dep_dec));
  assign imm_data = (dec_rs1idx == IDX_X1) ? x1_data : '0;
  assign wait_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    rs1idx_d   = rs1idx_q;
    rs1_data_d = rs1_data_q;
    wait_cnt_d = wait_cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rs1idx_d   = dec_rs1idx;
            wait_cnt_d = '0;
            if (imm_hit) begin
              rs1_data_d = imm_data;
              if (!rs1_rdy) state_d = ST_DONE;
            end else if (dep_dec) begin
              state_d = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt_d = wait_inc;
          if (!dep_lat) begin
            if (FAST_X1 && (rs1idx_q == IDX_X1)) begin
              rs1_data_d = x1_data;
              state_d    = ST_DONE;
            end else begin
              state_d    = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Hazards are not re-checked here: a grant always completes the read.
          if (rf_rd_gnt) begin
            rs1_data_d = rf_rd_data;
            state_d    = ST_DONE;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
        default: begin
          if (rs1_rdy) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rs1idx_q   <= '0;
      rs1_data_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rs1idx_q   <= rs1idx_d;
      rs1_data_q <= rs1_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign rf_rd_req = (state_q == ST_REQ);
  assign rf_rd_idx = rf_rd_req ? rs1idx_q : '0;
  assign rs1_vld   = (state_q == ST_DONE) | imm_hit;
  assign rs1_data  = (state_q == ST_DONE) ? rs1_data_q :
                     imm_hit              ? imm_data   : '0;
  assign ifu_hold  = ~flush & (state_q != ST_IDLE);
  assign wait_cnt  = wait_cnt_q;

endmodule
